// File: rtl/peasant_pkg.sv
// Shared types and default width for the shift-and-add (Russian-peasant) multiplier.
package peasant_pkg;

  localparam int PEASANT_NBITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } peasant_state_t;

endpackage

// File: rtl/peasant_step.sv
// One combinational iteration of the peasant algorithm: conditional accumulate,
// double the multiplicand, halve the multiplier.
module peasant_step
  import peasant_pkg::*;
#(
  parameter int NBITS = PEASANT_NBITS
) (
  input  logic [2*NBITS-1:0] a,
  input  logic [NBITS-1:0]   b,
  input  logic [2*NBITS-1:0] acc,
  output logic [2*NBITS-1:0] a_next,
  output logic [NBITS-1:0]   b_next,
  output logic [2*NBITS-1:0] acc_next,
  output logic               last
);

  always_comb begin
    acc_next = b[0] ? acc + a : acc;
    a_next   = a << 1;
    b_next   = b >> 1;
    // b <= 1 means this iteration consumes the final multiplier bit.
    last     = (b[NBITS-1:1] == '0);
  end

endmodule

// File: rtl/peasant_mult.sv
// Sequential unsigned multiplier with valid/ready handshakes on both sides.
// Define PEASANT_SWAP_EN to loop on the smaller operand (shorter latency).
module peasant_mult
  import peasant_pkg::*;
#(
  parameter int NBITS = PEASANT_NBITS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NBITS-1:0]   A,
  input  logic [NBITS-1:0]   B,
  input  logic               iValid,
  output logic               iReady,
  output logic [2*NBITS-1:0] result,
  output logic               oValid,
  input  logic               oReady
);

  peasant_state_t     state_q, state_d;
  logic [2*NBITS-1:0] a_q, a_d;
  logic [NBITS-1:0]   b_q, b_d;
  logic [2*NBITS-1:0] acc_q, acc_d;

  logic [2*NBITS-1:0] step_a, step_acc;
  logic [NBITS-1:0]   step_b;
  logic               step_last;

  peasant_step #(.NBITS(NBITS)) u_step (
    .a        (a_q),
    .b        (b_q),
    .acc      (acc_q),
    .a_next   (step_a),
    .b_next   (step_b),
    .acc_next (step_acc),
    .last     (step_last)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (iValid) begin
`ifdef PEASANT_SWAP_EN
          if (B > A) begin
            a_d = {{NBITS{1'b0}}, B};
            b_d = A;
          end else begin
            a_d = {{NBITS{1'b0}}, A};
            b_d = B;
          end
`else
          a_d = {{NBITS{1'b0}}, A};
          b_d = B;
`endif
          acc_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d   = step_a;
        b_d   = step_b;
        acc_d = step_acc;
        if (step_last) state_d = DONE;
      end
      DONE: begin
        if (oReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  // NOTE: all datapath registers are reset too, so result reads 0 the instant reset asserts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  assign iReady = (state_q == IDLE);
  assign oValid = (state_q == DONE);
  assign result = acc_q;

endmodule

// File: tb/tb_peasant_mult.sv
// Randomized self-checking bench for peasant_mult against a plain-arithmetic model.
`timescale 1ns/1ps
module tb_peasant_mult;

  localparam int W = 8;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [W-1:0]   A = '0;
  logic [W-1:0]   B = '0;
  logic           iValid = 1'b0;
  logic           iReady;
  logic [2*W-1:0] result;
  logic           oValid;
  logic           oReady = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  peasant_mult #(.NBITS(W)) dut (
    .clock  (clock),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .iValid (iValid),
    .iReady (iReady),
    .result (result),
    .oValid (oValid),
    .oReady (oReady)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Number of loop iterations: position of the top set bit of the loop operand, plus one, at least 1.
  function automatic int exp_cycles(input int a, input int b);
    int loop_op;
    int m;
    loop_op = b;
`ifdef PEASANT_SWAP_EN
    if (a < b) loop_op = a;
`endif
    m = -1;
    for (int i = 0; i < W; i++) if (loop_op[i]) m = i;
    return (m < 1) ? 1 : m + 1;
  endfunction

  task automatic run_op(input int a, input int b, input int stall, input bit scramble);
    int guard;
    int cycles;
    int prod;
    prod = a * b;
    @(negedge clock);
    A      = W'(a);
    B      = W'(b);
    iValid = 1'b1;
    oReady = (stall == 0);
    guard  = 0;
    while (!iReady && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    check("accept_ready", 32'(iReady), 1);
    @(posedge clock);
    #1;
    check("busy_iready", 32'(iReady), 0);
    check("busy_ovalid", 32'(oValid), 0);
    if (scramble) begin
      A = W'($urandom);
      B = W'($urandom);
    end
    cycles = 0;
    while (!oValid && cycles < 40) begin
      @(posedge clock);
      #1;
      cycles++;
    end
    iValid = 1'b0;
    check("calc_cycles", 32'(cycles), 32'(exp_cycles(a, b)));
    check("product", 32'(result), 32'(prod));
    for (int i = 0; i < stall; i++) begin
      @(posedge clock);
      #1;
      check("hold_ovalid", 32'(oValid), 1);
      check("hold_result", 32'(result), 32'(prod));
      check("hold_iready", 32'(iReady), 0);
    end
    oReady = 1'b1;
    @(posedge clock);
    #1;
    check("post_ovalid", 32'(oValid), 0);
    check("post_iready", 32'(iReady), 1);
    check("post_result", 32'(result), 32'(prod));
  endtask

  initial begin
    #1;
    check("rst_iready", 32'(iReady), 1);
    check("rst_ovalid", 32'(oValid), 0);
    check("rst_result", 32'(result), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    run_op(12, 11, 0, 1'b0);
    run_op(255, 255, 0, 1'b1);
    run_op(0, 200, 0, 1'b1);
    run_op(77, 0, 0, 1'b1);
    run_op(200, 1, 0, 1'b0);
    run_op(1, 200, 0, 1'b0);
    run_op(9, 7, 10, 1'b0);
    run_op(3, 5, 0, 1'b0);
    run_op(6, 7, 0, 1'b0);

    // Abort a long operation with an asynchronous reset between clock edges.
    @(negedge clock);
    A = 8'd255;
    B = 8'd255;
    iValid = 1'b1;
    @(posedge clock);
    #1;
    iValid = 1'b0;
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("abort_iready", 32'(iReady), 1);
    check("abort_ovalid", 32'(oValid), 0);
    check("abort_result", 32'(result), 0);
    @(negedge clock);
    check("abort_hold_ovalid", 32'(oValid), 0);
    reset = 1'b1;
    run_op(12, 11, 0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      int ra;
      int rb;
      int st;
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_op(ra, rb, st, $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
